// File: rtl/leadzero_pkg.sv
// leadzero_pkg: definitions shared by the leading-zero generator and counter.
//   CNT_W     width of a leading-zero count
//   Z_W       internal width for clamped counts and word bit offsets
//   IDLE/EMIT state codes, identical to the counter's
//   max_zero  largest meaningful count for a WIDTH x WORD group
package leadzero_pkg;

  localparam int unsigned CNT_W = 9;
  localparam int unsigned Z_W   = 10;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] EMIT = 2'b01;

  function automatic int unsigned max_zero(input int unsigned width,
                                           input int unsigned word);
    return width * word;
  endfunction

endpackage

// File: rtl/leadzero_gen_if.sv
// leadzero_gen_if: request and word-stream signals of the leading-zero generator.
//   ivalid/mode/zero/fill  request from the producer
//   ready                  generator can take a request
//   ovalid/data/olast      emitted word stream
// master = side issuing requests and consuming words; slave = generator.
interface leadzero_gen_if #(
  parameter int unsigned WIDTH = 8
);
  import leadzero_pkg::*;

  logic             ivalid;
  logic             mode;
  logic [CNT_W-1:0] zero;
  logic [WIDTH-1:0] fill;
  logic             ready;
  logic             ovalid;
  logic [WIDTH-1:0] data;
  logic             olast;

  modport master (
    output ivalid, mode, zero, fill,
    input  ready, ovalid, data, olast
  );

  modport slave (
    input  ivalid, mode, zero, fill,
    output ready, ovalid, data, olast
  );

endinterface

// File: rtl/leadzero_word.sv
// leadzero_word: combinational builder for word k of a group with z_i leading zeros.
//   z_i        clamped leading-zero count for the group
//   k_i        word index (0 = most significant word)
//   fill_i     pattern below the leading one and after it
//   word_o     word k
//   has_one_o  1 when word k holds the leading one
module leadzero_word
  import leadzero_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [Z_W-1:0]   z_i,
  input  logic [Z_W-1:0]   k_i,
  input  logic [WIDTH-1:0] fill_i,
  output logic [WIDTH-1:0] word_o,
  output logic             has_one_o
);

  logic [Z_W-1:0] base;
  logic [Z_W-1:0] top;
  logic [Z_W-1:0] off;
  logic [Z_W-1:0] p;

  always_comb begin
    base      = k_i * Z_W'(WIDTH);
    top       = base + Z_W'(WIDTH);
    // off/p only meaningful when base <= z_i < top
    off       = z_i - base;
    p         = Z_W'(WIDTH - 1) - off;
    word_o    = '0;
    has_one_o = 1'b0;
    if (z_i >= top) begin
      word_o = '0;
    end else if (z_i >= base) begin
      has_one_o = 1'b1;
      for (int unsigned b = 0; b < WIDTH; b++) begin
        if (Z_W'(b) == p) begin
          word_o[b] = 1'b1;
        end else if (Z_W'(b) < p) begin
          word_o[b] = fill_i[b];
        end
      end
    end else begin
      word_o = fill_i;
    end
  end

endmodule

// File: rtl/leadzero_gen.sv
// leadzero_gen: emits a group of WORD words, MSW first, whose concatenation has
// the requested number of leading zeros. Turbo mode ends the group at the word
// holding the leading one.
//   CLK    clock, rising edge
//   rst    synchronous reset, active-high
//   bus    slave side of leadzero_gen_if:
//            ivalid/mode/zero/fill in, ready out (1 in IDLE),
//            ovalid/data/olast out (registered)
module leadzero_gen
  import leadzero_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned WORD  = 4
) (
  input logic           CLK,
  input logic           rst,
  leadzero_gen_if.slave bus
);

  localparam logic [Z_W-1:0] MAXZ   = Z_W'(max_zero(WIDTH, WORD));
  localparam logic [Z_W-1:0] LAST_K = Z_W'(WORD - 1);

  logic [1:0]       state_q, state_d;
  logic [Z_W-1:0]   idx_q, idx_d;
  logic [Z_W-1:0]   z_q, z_d;
  logic [WIDTH-1:0] fill_q, fill_d;
  logic             mode_q, mode_d;
  logic             ovalid_q, ovalid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             olast_q, olast_d;

  logic             accept;
  logic [Z_W-1:0]   zero_ext;
  logic [Z_W-1:0]   z_clamp;
  logic [Z_W-1:0]   sel_z;
  logic [Z_W-1:0]   sel_k;
  logic [WIDTH-1:0] sel_fill;
  logic             sel_mode;
  logic [WIDTH-1:0] word;
  logic             has_one;
  logic             is_last;

  assign accept   = bus.ivalid && (state_q == IDLE);
  assign zero_ext = Z_W'(bus.zero);
  assign z_clamp  = (zero_ext > MAXZ) ? MAXZ : zero_ext;

  // Word 0 is built straight from the request on the accept edge so it is
  // valid the cycle after accept and back-to-back groups have no bubble.
  assign sel_z    = accept ? z_clamp   : z_q;
  assign sel_k    = accept ? '0        : idx_q;
  assign sel_fill = accept ? bus.fill  : fill_q;
  assign sel_mode = accept ? bus.mode  : mode_q;

  leadzero_word #(
    .WIDTH(WIDTH)
  ) u_word (
    .z_i      (sel_z),
    .k_i      (sel_k),
    .fill_i   (sel_fill),
    .word_o   (word),
    .has_one_o(has_one)
  );

  assign is_last = (sel_k == LAST_K) || (sel_mode && has_one);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    z_d      = z_q;
    fill_d   = fill_q;
    mode_d   = mode_q;
    ovalid_d = 1'b0;
    data_d   = '0;
    olast_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          z_d      = z_clamp;
          fill_d   = bus.fill;
          mode_d   = bus.mode;
          data_d   = word;
          ovalid_d = 1'b1;
          idx_d    = Z_W'(1);
          if (is_last) begin
            olast_d = 1'b1;
          end else begin
            state_d = EMIT;
          end
        end
      end
      EMIT: begin
        data_d   = word;
        ovalid_d = 1'b1;
        idx_d    = idx_q + Z_W'(1);
        if (is_last) begin
          olast_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      z_q      <= '0;
      fill_q   <= '0;
      mode_q   <= 1'b0;
      ovalid_q <= 1'b0;
      data_q   <= '0;
      olast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      z_q      <= z_d;
      fill_q   <= fill_d;
      mode_q   <= mode_d;
      ovalid_q <= ovalid_d;
      data_q   <= data_d;
      olast_q  <= olast_d;
    end
  end

  assign bus.ready  = (state_q == IDLE);
  assign bus.ovalid = ovalid_q;
  assign bus.data   = data_q;
  assign bus.olast  = olast_q;

endmodule

// File: tb/tb_leadzero_gen.sv
// tb_leadzero_gen: directed self-checking bench for leadzero_gen (WIDTH=8, WORD=4).
// A negedge monitor records every valid word and feeds a reference
// leading-zero counter that reports one count per completed group.
module tb_leadzero_gen;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   cyc;

  logic [9:0] obs[$];
  logic [9:0] exp_q[$];
  int         obs_cyc[$];
  int         cnts[$];
  int         lz_cnt;
  bit         lz_found;

  leadzero_gen_if #(.WIDTH(8)) bus ();

  leadzero_gen #(
    .WIDTH(8),
    .WORD (4)
  ) dut (
    .CLK(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    cyc      = 0;
    lz_cnt   = 0;
    lz_found = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.ovalid === 1'b1) begin
        obs.push_back({bus.ready, bus.olast, bus.data});
        obs_cyc.push_back(cyc);
        for (int b = 7; b >= 0; b--) begin
          if (!lz_found) begin
            if (bus.data[b]) lz_found = 1;
            else lz_cnt++;
          end
        end
        if (bus.olast) begin
          cnts.push_back(lz_cnt);
          lz_cnt   = 0;
          lz_found = 0;
        end
      end
      if (rst) begin
        lz_cnt   = 0;
        lz_found = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic exp_w(input logic [7:0] d, input logic l);
    exp_q.push_back({l, l, d});
  endtask

  task automatic check_stream(input string tag);
    int n;
    check({tag, "_len"}, obs.size(), exp_q.size());
    n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_w%0d", tag, i), obs[i], exp_q[i]);
    obs.delete();
    exp_q.delete();
    obs_cyc.delete();
  endtask

  task automatic send(input logic [8:0] z, input logic [7:0] f, input logic m);
    int n;
    n = 0;
    while (bus.ready !== 1'b1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("send_ready", bus.ready, 1'b1);
    bus.ivalid = 1'b1;
    bus.zero   = z;
    bus.fill   = f;
    bus.mode   = m;
    @(posedge clk);
    #1;
    bus.ivalid = 1'b0;
  endtask

  task automatic wait_last(input string tag);
    int n;
    bit seen;
    n    = 0;
    seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      if (bus.ovalid === 1'b1 && bus.olast === 1'b1) seen = 1;
      n++;
    end
    check({tag, "_done"}, seen, 1'b1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    bus.ivalid = 1'b0;
    bus.zero   = '0;
    bus.fill   = '0;
    bus.mode   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    obs.delete();
    obs_cyc.delete();
    cnts.delete();

    @(negedge clk);
    check("rst_ovalid", bus.ovalid, 1'b0);
    check("rst_ready",  bus.ready,  1'b1);
    check("rst_data",   bus.data,   8'h00);
    check("rst_olast",  bus.olast,  1'b0);
    @(posedge clk);
    #1;

    // 1: all-ones fill, no leading zeros
    send(9'd0, 8'hFF, 1'b0);
    check("t1_latency", bus.ovalid, 1'b1);
    wait_last("t1");
    check("t1_gap", obs_cyc[3] - obs_cyc[0], 3);
    exp_w(8'hFF, 0); exp_w(8'hFF, 0); exp_w(8'hFF, 0); exp_w(8'hFF, 1);
    check_stream("t1");

    // 2: leading one in word 1, ready high with the last word
    send(9'd11, 8'h00, 1'b0);
    wait_last("t2");
    exp_w(8'h00, 0); exp_w(8'h10, 0); exp_w(8'h00, 0); exp_w(8'h00, 1);
    check_stream("t2");

    // 3: turbo stops at word 1
    send(9'd11, 8'h0F, 1'b1);
    wait_last("t3");
    exp_w(8'h00, 0); exp_w(8'h1F, 1);
    check_stream("t3");

    // 4: clamp in turbo, then exact full count in normal mode
    send(9'd40, 8'hAA, 1'b1);
    wait_last("t4a");
    exp_w(8'h00, 0); exp_w(8'h00, 0); exp_w(8'h00, 0); exp_w(8'h00, 1);
    check_stream("t4a");
    send(9'd32, 8'hAA, 1'b0);
    wait_last("t4b");
    exp_w(8'h00, 0); exp_w(8'h00, 0); exp_w(8'h00, 0); exp_w(8'h00, 1);
    check_stream("t4b");

    // 5: reset after the second word drops the rest
    send(9'd5, 8'hA5, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t5_ovalid", bus.ovalid, 1'b0);
    check("t5_ready",  bus.ready,  1'b1);
    repeat (6) @(posedge clk);
    #1;
    exp_w(8'h05, 0); exp_w(8'hA5, 0);
    check_stream("t5");

    // 6: ivalid held high across two groups, then reference-counter checks
    cnts.delete();
    bus.ivalid = 1'b1;
    bus.zero   = 9'd3;
    bus.fill   = 8'h00;
    bus.mode   = 1'b0;
    @(posedge clk);
    #1;
    bus.zero = 9'd20;
    repeat (4) @(posedge clk);
    #1;
    bus.ivalid = 1'b0;
    wait_last("t6");
    check("t6_nobubble", obs_cyc[4] - obs_cyc[3], 1);
    exp_w(8'h10, 0); exp_w(8'h00, 0); exp_w(8'h00, 0); exp_w(8'h00, 1);
    exp_w(8'h00, 0); exp_w(8'h00, 0); exp_w(8'h08, 0); exp_w(8'h00, 1);
    check_stream("t6");

    send(9'd20, 8'hFF, 1'b1);
    wait_last("t6b");
    exp_w(8'h00, 0); exp_w(8'h00, 0); exp_w(8'h0F, 1);
    check_stream("t6b");
    send(9'd40, 8'h00, 1'b1);
    wait_last("t6c");
    send(9'd9, 8'h55, 1'b0);
    wait_last("t6d");
    exp_w(8'h00, 0); exp_w(8'h00, 0); exp_w(8'h00, 0); exp_w(8'h00, 1);
    exp_w(8'h00, 0); exp_w(8'h55, 0); exp_w(8'h55, 0); exp_w(8'h55, 1);
    check_stream("t6cd");

    check("lz_groups", cnts.size(), 5);
    check("lz_g0", cnts[0], 3);
    check("lz_g1", cnts[1], 20);
    check("lz_g2", cnts[2], 20);
    check("lz_g3", cnts[3], 32);
    check("lz_g4", cnts[4], 9);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
